// File: rtl/id_ex_stage.sv
// id_ex_stage: register file, load-use hazard detect and ID/EX pipeline register
// Inputs: ID_* decoded instruction from IF/ID, WB_* register write-back port,
//   EX_flush squash from execute. Outputs: HZ_stall freezes PC and IF/ID,
//   EX_* registered operands/fields/control, HZ_stall_cnt saturating stall count.
module id_ex_stage #(
  parameter int CTRL_W       = 11,
  parameter int MEMREAD_BIT  = 5,
  parameter int REGWRITE_BIT = 10
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic [31:0]       ID_pc,
  input  logic [31:0]       ID_instruction,
  input  logic [CTRL_W-1:0] ID_ctrl,
  input  logic              ID_valid,
  input  logic              WB_we,
  input  logic [4:0]        WB_addr,
  input  logic [31:0]       WB_data,
  input  logic              EX_flush,
  output logic              HZ_stall,
  output logic              EX_valid,
  output logic [CTRL_W-1:0] EX_ctrl,
  output logic [31:0]       EX_pc,
  output logic [31:0]       EX_rs_data,
  output logic [31:0]       EX_rt_data,
  output logic [31:0]       EX_imm,
  output logic [4:0]        EX_rs,
  output logic [4:0]        EX_rt,
  output logic [4:0]        EX_rd,
  output logic [4:0]        EX_shamt,
  output logic [5:0]        EX_funct,
  output logic [15:0]       HZ_stall_cnt
);
  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       pc;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [31:0]       imm;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
  } pipe_t;
  pipe_t       pipe_q, pipe_d;
  logic [31:0] rf_q [32];
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  rs, rt;
  logic [31:0] rs_rd, rt_rd;
  logic        wr, bubble;
  // opcode and RegWrite are carried but not interpreted here
  logic        unused_ok;
  assign unused_ok = ^{ID_instruction[31:26], ID_ctrl[REGWRITE_BIT]};
  assign rs = ID_instruction[25:21];
  assign rt = ID_instruction[20:16];
  assign wr = WB_we && WB_addr != 5'd0;
  // write-through so a same-cycle write-back is seen by the decoding instruction
  assign rs_rd = (wr && WB_addr == rs) ? WB_data : rf_q[rs];
  assign rt_rd = (wr && WB_addr == rt) ? WB_data : rf_q[rt];
  // rt is compared for every opcode, even when it is a destination
  assign HZ_stall = ID_valid && pipe_q.valid && pipe_q.ctrl[MEMREAD_BIT] && pipe_q.rt != 5'd0 &&
                    (pipe_q.rt == rs || pipe_q.rt == rt) && !EX_flush;
  assign bubble = EX_flush || HZ_stall || !ID_valid;
  always_comb
    pipe_d = bubble ? '0 : pipe_t'{1'b1, ID_ctrl, ID_pc, rs_rd, rt_rd,
                                   {{16{ID_instruction[15]}}, ID_instruction[15:0]},
                                   rs, rt, ID_instruction[15:11], ID_instruction[10:6], ID_instruction[5:0]};
  assign cnt_d = (HZ_stall && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      pipe_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
      if (wr) rf_q[WB_addr] <= WB_data;
    end
  end
  assign EX_valid     = pipe_q.valid;
  assign EX_ctrl      = pipe_q.ctrl;
  assign EX_pc        = pipe_q.pc;
  assign EX_rs_data   = pipe_q.rs_data;
  assign EX_rt_data   = pipe_q.rt_data;
  assign EX_imm       = pipe_q.imm;
  assign EX_rs        = pipe_q.rs;
  assign EX_rt        = pipe_q.rt;
  assign EX_rd        = pipe_q.rd;
  assign EX_shamt     = pipe_q.shamt;
  assign EX_funct     = pipe_q.funct;
  assign HZ_stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
  logic        SYS_clk = 1'b0, SYS_reset = 1'b0;
  logic [31:0] ID_pc = '0, ID_instruction = '0;
  logic [10:0] ID_ctrl = '0;
  logic        ID_valid = 1'b0, WB_we = 1'b0, EX_flush = 1'b0;
  logic [4:0]  WB_addr = '0;
  logic [31:0] WB_data = '0;
  logic        HZ_stall, EX_valid;
  logic [10:0] EX_ctrl;
  logic [31:0] EX_pc, EX_rs_data, EX_rt_data, EX_imm;
  logic [4:0]  EX_rs, EX_rt, EX_rd, EX_shamt;
  logic [5:0]  EX_funct;
  logic [15:0] HZ_stall_cnt;

  id_ex_stage dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .ID_pc(ID_pc), .ID_instruction(ID_instruction),
    .ID_ctrl(ID_ctrl), .ID_valid(ID_valid), .WB_we(WB_we), .WB_addr(WB_addr), .WB_data(WB_data),
    .EX_flush(EX_flush), .HZ_stall(HZ_stall), .EX_valid(EX_valid), .EX_ctrl(EX_ctrl),
    .EX_pc(EX_pc), .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data), .EX_imm(EX_imm),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd), .EX_shamt(EX_shamt), .EX_funct(EX_funct),
    .HZ_stall_cnt(HZ_stall_cnt)
  );

  always #5 SYS_clk = ~SYS_clk;

  typedef struct {
    logic        v;
    logic [10:0] ctrl;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur = '{default: 0};
  logic [31:0] regs [32];
  logic [15:0] cnt_m = '0;
  logic        init_done = 1'b0, hz_seen = 1'b0;
  int          n_chk = 0, n_fail = 0;

  localparam logic [31:0] ADD5 = 32'h00A01820, LW = 32'h8D280004, ADD8 = 32'h01085020;
  localparam logic [10:0] C_ALU = 11'h401, C_LW = 11'h420;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One decode cycle: drive inputs, check the combinational stall, and queue
  // the ID/EX contents the model predicts for the following edge.
  task automatic cycle(input logic rst, input logic [31:0] instr, input logic [10:0] ctl,
                       input logic vld, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic fl);
    exp_t        e;
    logic        st;
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, pcv;
    rs  = instr[25:21];
    rt  = instr[20:16];
    pcv = $urandom;
    SYS_reset = rst; ID_pc = pcv; ID_instruction = instr; ID_ctrl = ctl; ID_valid = vld;
    WB_we = we; WB_addr = wa; WB_data = wd; EX_flush = fl;
    #1;
    st = vld && cur.v && cur.ctrl[5] && cur.rt != 0 && (cur.rt == rs || cur.rt == rt) && !fl;
    hz_seen = HZ_stall;
    if (init_done) chk("hz_stall", 32'(HZ_stall), 32'(st));
    rsd = (we && wa != 0 && wa == rs) ? wd : (rs == 0 ? 32'h0 : regs[rs]);
    rtd = (we && wa != 0 && wa == rt) ? wd : (rt == 0 ? 32'h0 : regs[rt]);
    e = '{default: 0};
    if (!rst) begin
      e.cnt = (st && cnt_m != 16'hFFFF) ? cnt_m + 16'd1 : cnt_m;
      if (vld && !fl && !st) begin
        e.v = 1'b1; e.ctrl = ctl; e.pc = pcv; e.rsd = rsd; e.rtd = rtd;
        e.imm = {{16{instr[15]}}, instr[15:0]};
        e.rs = rs; e.rt = rt; e.rd = instr[15:11]; e.sh = instr[10:6]; e.fn = instr[5:0];
      end
    end
    @(posedge SYS_clk);
    sb.push_back(e);
    cur = e;
    cnt_m = e.cnt;
    if (rst) foreach (regs[i]) regs[i] = '0;
    else if (we && wa != 0) regs[wa] = wd;
    init_done = 1'b1;
    #1;
  endtask

  always @(negedge SYS_clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ex_valid", 32'(EX_valid), 32'(e.v));
      chk("ex_ctrl", 32'(EX_ctrl), 32'(e.ctrl));
      chk("ex_pc", EX_pc, e.pc);
      chk("ex_rs_data", EX_rs_data, e.rsd);
      chk("ex_rt_data", EX_rt_data, e.rtd);
      chk("ex_imm", EX_imm, e.imm);
      chk("ex_rs", 32'(EX_rs), 32'(e.rs));
      chk("ex_rt", 32'(EX_rt), 32'(e.rt));
      chk("ex_rd", 32'(EX_rd), 32'(e.rd));
      chk("ex_shamt", 32'(EX_shamt), 32'(e.sh));
      chk("ex_funct", 32'(EX_funct), 32'(e.fn));
      chk("stall_cnt", 32'(HZ_stall_cnt), 32'(e.cnt));
    end
  end

  initial begin
    foreach (regs[i]) regs[i] = '0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(EX_valid), 32'h0);
    chk("rst_cnt", 32'(HZ_stall_cnt), 32'h0);
    // plain read after write-back
    cycle(0, 0, 0, 0, 1, 5'd5, 32'h12345678, 0);
    cycle(0, ADD5, C_ALU, 1, 0, 0, 0, 0);
    chk("add_rs_data", EX_rs_data, 32'h12345678);
    chk("add_rt_data", EX_rt_data, 32'h0);
    chk("add_rd", 32'(EX_rd), 32'd3);
    chk("add_funct", 32'(EX_funct), 32'h20);
    chk("add_valid", 32'(EX_valid), 32'h1);
    // same-cycle write-back bypass
    cycle(0, ADD5, C_ALU, 1, 1, 5'd5, 32'hDEADBEEF, 0);
    chk("bypass_rs_data", EX_rs_data, 32'hDEADBEEF);
    // r0 stays zero
    cycle(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, 0);
    cycle(0, 32'h00001820, C_ALU, 1, 1, 5'd0, 32'hFFFFFFFF, 0);
    chk("r0_rs_data", EX_rs_data, 32'h0);
    chk("r0_rt_data", EX_rt_data, 32'h0);
    // load-use stall
    cycle(0, LW, C_LW, 1, 0, 0, 0, 0);
    cycle(0, ADD8, C_ALU, 1, 0, 0, 0, 0);
    chk("lu_stall", 32'(hz_seen), 32'h1);
    chk("lu_bubble", 32'(EX_valid), 32'h0);
    chk("lu_cnt", 32'(HZ_stall_cnt), 32'h1);
    cycle(0, ADD8, C_ALU, 1, 0, 0, 0, 0);
    chk("lu_stall_clear", 32'(hz_seen), 32'h0);
    chk("lu_issue_valid", 32'(EX_valid), 32'h1);
    chk("lu_issue_rs", 32'(EX_rs), 32'd8);
    chk("lu_issue_rt", 32'(EX_rt), 32'd8);
    // flush beats stall
    cycle(0, LW, C_LW, 1, 0, 0, 0, 0);
    cycle(0, ADD8, C_ALU, 1, 0, 0, 0, 1);
    chk("fl_stall", 32'(hz_seen), 32'h0);
    chk("fl_bubble", 32'(EX_valid), 32'h0);
    chk("fl_cnt", 32'(HZ_stall_cnt), 32'h1);
    // sign-extended immediate, then reset clears everything
    cycle(0, 32'h2128FFFC, C_ALU, 1, 0, 0, 0, 0);
    chk("addi_imm", EX_imm, 32'hFFFFFFFC);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst2_valid", 32'(EX_valid), 32'h0);
    chk("rst2_imm", EX_imm, 32'h0);
    chk("rst2_pc", EX_pc, 32'h0);
    chk("rst2_cnt", 32'(HZ_stall_cnt), 32'h0);
    cycle(0, ADD5, C_ALU, 1, 0, 0, 0, 0);
    chk("rst2_rf_r5", EX_rs_data, 32'h0);
    // reset arriving mid-stall
    cycle(0, LW, C_LW, 1, 0, 0, 0, 0);
    cycle(1, ADD8, C_ALU, 1, 0, 0, 0, 0);
    chk("rstst_before", 32'(hz_seen), 32'h1);
    chk("rstst_after", 32'(HZ_stall), 32'h0);
    chk("rstst_valid", 32'(EX_valid), 32'h0);
    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [10:0] ctl;
      ins = {6'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      ctl = 11'($urandom);
      ctl[5] = ($urandom_range(0, 9) < 4);
      cycle($urandom_range(0, 49) == 0, ins, ctl, $urandom_range(0, 9) < 8,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge SYS_clk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
